// File: rtl/muestreador_fifo.sv
// Sample pacer: buffers upstream samples and releases one per rising edge of the
// selected sample-rate square wave, with prefill, underrun tracking and glitch-free rate switching.
//
// state | meaning
// IDLE  | pacing off, no strobes
// ARM   | waiting for FIFO level >= PREFILL, ticks ignored
// RUN   | one strobe per tick, popping the FIFO head when available
module muestreador_fifo #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int PREFILL     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock_in,
  input  logic                     reset_n,
  input  logic [7:0]               samp_rates,
  input  logic [2:0]               rate_sel,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_strobe,
  output logic [7:0]               underrun_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               sel_q, sel_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     prev_q, prev_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_strobe_q, out_strobe_d;
  logic [7:0]               underrun_q, underrun_d;
  logic                     in_ready_q, in_ready_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];

  logic                     sel_change;
  logic                     tick;
  logic                     push;
  logic                     pop;

  // On a rate switch the whole chain and the edge history preload the new raw bit,
  // so the switch itself can never look like a rising edge.
  always_comb begin
    sel_change = (rate_sel != sel_q);
    sel_d      = rate_sel;
    if (sel_change) begin
      sync_d = {SYNC_STAGES{samp_rates[rate_sel]}};
      prev_d = samp_rates[rate_sel];
    end else begin
      sync_d = {sync_q[SYNC_STAGES-2:0], samp_rates[sel_q]};
      prev_d = sync_q[SYNC_STAGES-1];
    end
    tick = sync_q[SYNC_STAGES-1] & ~prev_q & ~sel_change;
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    underrun_d   = underrun_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    push         = in_valid & in_ready_q;
    pop          = 1'b0;

    if (flush) begin
      push     = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      unique case (state_q)
        ST_IDLE: if (enable) state_d = ST_ARM;
        ST_ARM:  if (!enable) state_d = ST_IDLE;
        default: state_d = ST_ARM;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_ARM;
        end
        ST_ARM: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (level_q >= LVL_W'(PREFILL)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            out_strobe_d = 1'b1;
            if (level_q != '0) begin
              pop        = 1'b1;
              out_data_d = mem_q[rd_ptr_q];
            end else begin
              // Empty tick still strobes so the DAC repeats the last sample.
              if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
              state_d = ST_ARM;
            end
          end
          if (!enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    in_ready_d = (level_d < LVL_W'(DEPTH));
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      underrun_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      underrun_q   <= underrun_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready     = in_ready_q;
  assign out_data     = out_data_q;
  assign out_strobe   = out_strobe_q;
  assign underrun_cnt = underrun_q;
  assign level        = level_q;

endmodule

// File: tb/tb_muestreador_fifo.sv
// Directed bench for muestreador_fifo: prefill, pacing latency, underrun, full FIFO,
// rate switching, flush, mid-run reset and disable.
module tb_muestreador_fifo;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic [7:0]  samp_rates;
  logic [2:0]  rate_sel;
  logic        enable;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_strobe;
  logic [7:0]  underrun_cnt;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ph7    = 625;
  int ph0    = 0;
  bit gen7   = 0;
  bit gen0   = 0;
  int rise7  = -1000;
  int rise0  = -1000;

  always #5 clock_in = ~clock_in;

  muestreador_fifo #(.DATA_W(16), .DEPTH(16), .PREFILL(4), .SYNC_STAGES(2)) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .samp_rates   (samp_rates),
    .rate_sel     (rate_sel),
    .enable       (enable),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_strobe   (out_strobe),
    .underrun_cnt (underrun_cnt),
    .level        (level)
  );

  // One clock; waves advance right after the edge, so a new high is first sampled at cyc+1.
  task automatic step();
    @(posedge clock_in);
    #1;
    cyc++;
    if (gen7) begin
      ph7 = (ph7 + 1) % 1250;
      if (ph7 == 0) rise7 = cyc + 1;
      samp_rates[7] = (ph7 < 625);
    end
    if (gen0) begin
      ph0 = (ph0 + 1) % 7500;
      if (ph0 == 0) rise0 = cyc + 1;
      samp_rates[0] = (ph0 < 3750);
    end
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output bit found, output int at);
    found = 0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (out_strobe === 1'b1) begin
        found = 1;
        at    = cyc;
      end
    end
  endtask

  task automatic pulse_tick(input int b, output bit s, output logic [15:0] d);
    samp_rates[b] = 1'b0;
    repeat (3) step();
    samp_rates[b] = 1'b1;
    s = 0;
    d = 'x;
    for (int i = 0; i < 6 && !s; i++) begin
      step();
      if (out_strobe === 1'b1) begin
        s = 1;
        d = out_data;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; samp_rates = '0; rate_sel = '0; enable = 0; flush = 0;
    in_data = '0; in_valid = 0;
    repeat (2) @(posedge clock_in);
    #1;
    checks++; if (level !== 5'd0)        begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (out_data !== 16'h0)    begin errors++; $display("FAIL rst_data got %h want 0000", out_data); end
    checks++; if (out_strobe !== 1'b0)   begin errors++; $display("FAIL rst_strobe got %b want 0", out_strobe); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_underrun got %0d want 0", underrun_cnt); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_ready got %b want 0", in_ready); end
    @(negedge clock_in);
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rel_ready got %b want 1", in_ready); end
  endtask

  task automatic test_prefill_run();
    bit f; int at;
    rate_sel = 3'd7;
    enable   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push(16'(k));
      checks++; if (level !== 5'(k)) begin errors++; $display("FAIL fill_level got %0d want %0d", level, k); end
    end
    ph7 = 625; samp_rates[7] = 1'b0; gen7 = 1;
    for (int k = 1; k <= 4; k++) begin
      wait_strobe(1400, f, at);
      checks++; if (!f || out_data !== 16'(k)) begin errors++; $display("FAIL run_data found=%0d got %h want %h", f, out_data, 16'(k)); end
      checks++; if (at !== rise7 + 2) begin errors++; $display("FAIL run_latency got cyc %0d want %0d", at, rise7 + 2); end
      step();
      checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL run_width got %b want 0", out_strobe); end
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL run_drain got %0d want 0", level); end
  endtask

  task automatic test_underrun();
    bit f; int at;
    wait_strobe(1400, f, at);
    checks++; if (!f || out_data !== 16'h0004) begin errors++; $display("FAIL ur_data found=%0d got %h want 0004", f, out_data); end
    checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL ur_count got %0d want 1", underrun_cnt); end
    push(16'h0010); push(16'h0011); push(16'h0012);
    wait_strobe(1300, f, at);
    checks++; if (f) begin errors++; $display("FAIL ur_armquiet got strobe at %0d want none", at); end
    checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL ur_hold got %0d want 1", underrun_cnt); end
    push(16'h0013);
    wait_strobe(1400, f, at);
    checks++; if (!f || out_data !== 16'h0010) begin errors++; $display("FAIL ur_rearm found=%0d got %h want 0010", f, out_data); end
    checks++; if (at !== rise7 + 2) begin errors++; $display("FAIL ur_latency got %0d want %0d", at, rise7 + 2); end
  endtask

  task automatic test_full();
    bit s; logic [15:0] d; int exp_lvl;
    gen7 = 0; samp_rates[7] = 1'b0;
    exp_lvl = 3;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 16'h0020 + 16'(i);
      step();
      if (exp_lvl < 16) exp_lvl++;
      checks++; if (level !== 5'(exp_lvl)) begin errors++; $display("FAIL full_level got %0d want %0d", level, exp_lvl); end
      checks++; if (in_ready !== (exp_lvl < 16)) begin errors++; $display("FAIL full_ready got %b want %b", in_ready, exp_lvl < 16); end
    end
    in_valid = 1'b0;
    pulse_tick(7, s, d);
    checks++; if (!s || d !== 16'h0011) begin errors++; $display("FAIL full_pop found=%0d got %h want 0011", s, d); end
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_poplvl got %0d want 15", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_reraise got %b want 1", in_ready); end
  endtask

  task automatic test_rate_switch();
    bit f; int at; int first;
    samp_rates[0] = 1'b1;
    ph0 = 3000; gen0 = 1;
    rate_sel = 3'd0;
    wait_strobe(8000, f, at);
    first = at;
    checks++; if (!f || out_data !== 16'h0012) begin errors++; $display("FAIL sw_data1 found=%0d got %h want 0012", f, out_data); end
    checks++; if (at !== rise0 + 2) begin errors++; $display("FAIL sw_latency got %0d want %0d", at, rise0 + 2); end
    wait_strobe(8000, f, at);
    checks++; if (!f || out_data !== 16'h0013) begin errors++; $display("FAIL sw_data2 found=%0d got %h want 0013", f, out_data); end
    checks++; if (at - first !== 7500) begin errors++; $display("FAIL sw_period got %0d want 7500", at - first); end
    gen0 = 0;
  endtask

  task automatic test_flush();
    bit s; logic [15:0] d;
    for (int k = 0; k < 8; k++) begin
      pulse_tick(0, s, d);
      checks++; if (!s || d !== 16'h0020 + 16'(k)) begin errors++; $display("FAIL fl_pop found=%0d got %h want %h", s, d, 16'h0020 + 16'(k)); end
    end
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL fl_pre got %0d want 5", level); end
    samp_rates[0] = 1'b0;
    repeat (3) step();
    samp_rates[0] = 1'b1;
    step(); step();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h00AA;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_strobe !== 1'b0) begin errors++; $display("FAIL fl_strobe got %b want 0", out_strobe); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL fl_level got %0d want 0", level); end
    checks++; if (out_data !== 16'h0027) begin errors++; $display("FAIL fl_data got %h want 0027", out_data); end
    checks++; if (underrun_cnt !== 8'd1) begin errors++; $display("FAIL fl_underrun got %0d want 1", underrun_cnt); end
    pulse_tick(0, s, d);
    checks++; if (s || underrun_cnt !== 8'd1) begin errors++; $display("FAIL fl_arm strobe=%0d underrun %0d want 0 and 1", s, underrun_cnt); end
    push(16'h0030); push(16'h0031); push(16'h0032); push(16'h0033);
    pulse_tick(0, s, d);
    checks++; if (!s || d !== 16'h0030) begin errors++; $display("FAIL fl_resume found=%0d got %h want 0030", s, d); end
  endtask

  task automatic test_reset_mid();
    bit s; logic [15:0] d;
    step();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_data !== 16'h0)    begin errors++; $display("FAIL mr_data got %h want 0000", out_data); end
    checks++; if (level !== 5'd0)        begin errors++; $display("FAIL mr_level got %0d want 0", level); end
    checks++; if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL mr_underrun got %0d want 0", underrun_cnt); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL mr_ready got %b want 0", in_ready); end
    enable = 1'b0;
    step();
    #3;
    reset_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_rel_ready got %b want 1", in_ready); end
    push(16'h0040); push(16'h0041); push(16'h0042); push(16'h0043);
    pulse_tick(0, s, d);
    checks++; if (s) begin errors++; $display("FAIL mr_idle got strobe want none"); end
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL mr_keep got %0d want 4", level); end
    enable = 1'b1;
    pulse_tick(0, s, d);
    checks++; if (!s || d !== 16'h0040) begin errors++; $display("FAIL mr_run found=%0d got %h want 0040", s, d); end
  endtask

  task automatic test_disable();
    bit s; logic [15:0] d;
    samp_rates[0] = 1'b0;
    repeat (3) step();
    samp_rates[0] = 1'b1;
    step(); step();
    enable = 1'b0;
    step();
    checks++; if (out_strobe !== 1'b1 || out_data !== 16'h0041) begin errors++; $display("FAIL dis_served strobe %b data %h want 1 0041", out_strobe, out_data); end
    pulse_tick(0, s, d);
    checks++; if (s) begin errors++; $display("FAIL dis_idle got strobe want none"); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL dis_level got %0d want 2", level); end
  endtask

  initial begin
    test_reset();
    test_prefill_run();
    test_underrun();
    test_full();
    test_rate_switch();
    test_flush();
    test_reset_mid();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
